// File: rtl/mos6502_bus_sequencer.sv
// Purpose: time-multiplexes 6502 core bus accesses onto one 8-bit pin bus (addr-lo, optional addr-hi, data).
// Latency: first ale_lo two cycles after cpu_req is first seen; cpu_ack at t+4+WAIT_CYCLES (page miss) or t+3+WAIT_CYCLES (page hit).
// Backpressure: cpu_req is held until cpu_ack; ext_wait stretches the data phase up to MAX_WAIT cycles, then times out with bus_err.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_req/addr/we/dout            request side from the core (held stable until cpu_ack)
//   cpu_din, cpu_ack, bus_err       completion side to the core (all registered)
//   bus_out, bus_in                 multiplexed pin bus out / read data in
//   ale_lo, ale_hi, wr_n, rd_n      strobes for the external address latch and memory
//   ext_wait                        external wait request, synchronous to clk
module mos6502_bus_sequencer #(
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_WAIT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        bus_err,
  output logic [7:0]  bus_out,
  input  logic [7:0]  bus_in,
  output logic        ale_lo,
  output logic        ale_hi,
  output logic        wr_n,
  output logic        rd_n,
  input  logic        ext_wait
);

  typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, DATA, ACK} state_t;

  localparam logic [3:0] BASE_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] EXT_LIMIT = 8'(MAX_WAIT);

  state_t      state;
  logic [15:0] addr_r;
  logic        we_r;
  logic [7:0]  dout_r;
  logic [7:0]  last_hi;
  logic        page_vld;
  logic        req_q;
  logic [3:0]  base_cnt;
  logic [7:0]  ext_cnt;

  // Outputs are registered together with the state they belong to, so the
  // pins always show the phase the FSM is currently in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_r   <= 16'h0000;
      we_r     <= 1'b0;
      dout_r   <= 8'h00;
      last_hi  <= 8'h00;
      page_vld <= 1'b0;
      req_q    <= 1'b0;
      base_cnt <= 4'd0;
      ext_cnt  <= 8'd0;
      cpu_din  <= 8'h00;
      cpu_ack  <= 1'b0;
      bus_err  <= 1'b0;
      bus_out  <= 8'h00;
      ale_lo   <= 1'b0;
      ale_hi   <= 1'b0;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
    end else begin
      // The request is registered once before IDLE acts on it; requiring the
      // live request as well means a request withdrawn after the ack edge
      // never starts a spurious access.
      req_q <= cpu_req;

      case (state)
        IDLE: begin
          if (cpu_req && req_q) begin
            addr_r  <= cpu_addr;
            we_r    <= cpu_we;
            dout_r  <= cpu_dout;
            bus_out <= cpu_addr[7:0];
            ale_lo  <= 1'b1;
            state   <= ADDR_LO;
          end
        end

        ADDR_LO: begin
          ale_lo   <= 1'b0;
          base_cnt <= BASE_LAST;
          ext_cnt  <= 8'd0;
          if (page_vld && (addr_r[15:8] == last_hi)) begin
            // External latch already holds this high byte: skip ADDR_HI.
            bus_out <= we_r ? dout_r : 8'h00;
            wr_n    <= ~we_r;
            rd_n    <= we_r;
            state   <= DATA;
          end else begin
            bus_out <= addr_r[15:8];
            ale_hi  <= 1'b1;
            state   <= ADDR_HI;
          end
        end

        ADDR_HI: begin
          ale_hi   <= 1'b0;
          last_hi  <= addr_r[15:8];
          page_vld <= 1'b1;
          bus_out  <= we_r ? dout_r : 8'h00;
          wr_n     <= ~we_r;
          rd_n     <= we_r;
          state    <= DATA;
        end

        DATA: begin
          if (base_cnt != 4'd0) begin
            base_cnt <= base_cnt - 4'd1;
          end else if (ext_wait && (ext_cnt != EXT_LIMIT)) begin
            ext_cnt <= ext_cnt + 8'd1;
          end else begin
            // Final data cycle. ext_wait still high here can only mean the
            // extension budget is spent: a timeout.
            bus_out <= 8'h00;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            cpu_ack <= 1'b1;
            bus_err <= ext_wait;
            if (ext_wait) begin
              // The latch contents are suspect after a hung access.
              page_vld <= 1'b0;
            end
            if (!we_r) begin
              cpu_din <= ext_wait ? 8'hFF : bus_in;
            end
            state <= ACK;
          end
        end

        ACK: begin
          cpu_ack <= 1'b0;
          bus_err <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502_bus_sequencer.sv
// Directed bench: a timeline model plans every access (pin phases, ack cycle,
// read data) from the access rules, drives stimulus from that timeline and
// compares every DUT output against it on each cycle.
module tb_mos6502_bus_sequencer;

  localparam int W  = 1;
  localparam int MW = 4;
  localparam int NC = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic        bus_err;
  logic [7:0]  bus_out;
  logic [7:0]  bus_in = 8'hEE;
  logic        ale_lo;
  logic        ale_hi;
  logic        wr_n;
  logic        rd_n;
  logic        ext_wait = 1'b0;

  mos6502_bus_sequencer #(.WAIT_CYCLES(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .bus_err(bus_err), .bus_out(bus_out), .bus_in(bus_in), .ale_lo(ale_lo),
    .ale_hi(ale_hi), .wr_n(wr_n), .rd_n(rd_n), .ext_wait(ext_wait)
  );

  always #5 clk = ~clk;

  // Stimulus timeline (value held during cycle c)
  logic        st_req [NC];
  logic [15:0] st_addr[NC];
  logic        st_we  [NC];
  logic [7:0]  st_dout[NC];
  logic [7:0]  st_bin [NC];
  logic        st_ext [NC];
  logic        st_rst [NC];
  // Expected outputs during cycle c
  logic [7:0]  ex_bus [NC];
  logic [7:0]  ex_din [NC];
  logic        ex_lo  [NC];
  logic        ex_hi  [NC];
  logic        ex_wr_n[NC];
  logic        ex_rd_n[NC];
  logic        ex_ack [NC];
  logic        ex_err [NC];

  bit         pv;
  logic [7:0] lhi;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         a1, a2, a3, a4, a4b, a6, a7, a8, a9;

  task automatic check(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, exp);
    end
  endtask

  // Plans one access whose request is high from cycle t; stimulus is written
  // from fill_from (t+1 when the request simply stays high after a previous ack).
  // ext_n = number of cycles the memory asks to extend; > MW means it hangs.
  task automatic plan(input int t, input int fill_from, input logic [15:0] addr, input logic we,
                      input logic [7:0] dout, input logic [7:0] din_base, input int ext_n,
                      output int ack);
    int   first, c, n, a;
    bit   miss, tmo;
    first = t + 2;
    miss  = !pv || (lhi != addr[15:8]);
    tmo   = ext_n > MW;
    n     = W + (tmo ? MW : ext_n);
    ex_bus[first] = addr[7:0];
    ex_lo[first]  = 1'b1;
    c = first + 1;
    if (miss) begin
      ex_bus[c] = addr[15:8];
      ex_hi[c]  = 1'b1;
      c++;
      lhi = addr[15:8];
      pv  = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      ex_bus[c+k]  = we ? dout : 8'h00;
      ex_wr_n[c+k] = !we;
      ex_rd_n[c+k] = we;
      st_bin[c+k]  = din_base + 8'(k);
      st_ext[c+k]  = (k >= W - 1) && (k < W - 1 + ext_n);
    end
    a = c + n;
    ex_ack[a] = 1'b1;
    ex_err[a] = tmo;
    if (!we) begin
      for (int j = a; j < NC; j++) ex_din[j] = tmo ? 8'hFF : din_base + 8'(n - 1);
    end
    if (tmo) pv = 1'b0;
    for (int j = fill_from; j <= a; j++) begin
      st_req[j]  = 1'b1;
      st_addr[j] = addr;
      st_we[j]   = we;
      st_dout[j] = dout;
    end
    ack = a;
  endtask

  // Reset pulled mid-cycle r, released mid-cycle rel: everything idles from r.
  task automatic plan_reset(input int r, input int rel);
    for (int j = r; j < NC; j++) begin
      ex_bus[j] = 8'h00; ex_din[j] = 8'h00; ex_lo[j] = 1'b0; ex_hi[j] = 1'b0;
      ex_wr_n[j] = 1'b1; ex_rd_n[j] = 1'b1; ex_ack[j] = 1'b0; ex_err[j] = 1'b0;
      st_req[j] = 1'b0; st_ext[j] = 1'b0;
    end
    for (int j = r; j < rel; j++) st_rst[j] = 1'b0;
    pv = 1'b0;
  endtask

  // Per-cycle compare against the planned timeline
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("bus_out", cyc, 16'(bus_out), 16'(ex_bus[cyc]));
      check("ale_lo",  cyc, 16'(ale_lo),  16'(ex_lo[cyc]));
      check("ale_hi",  cyc, 16'(ale_hi),  16'(ex_hi[cyc]));
      check("wr_n",    cyc, 16'(wr_n),    16'(ex_wr_n[cyc]));
      check("rd_n",    cyc, 16'(rd_n),    16'(ex_rd_n[cyc]));
      check("cpu_ack", cyc, 16'(cpu_ack), 16'(ex_ack[cyc]));
      check("bus_err", cyc, 16'(bus_err), 16'(ex_err[cyc]));
      check("cpu_din", cyc, 16'(cpu_din), 16'(ex_din[cyc]));
      check("one_strobe", cyc,
            16'((32'(ale_lo) + 32'(ale_hi) + 32'(!wr_n) + 32'(!rd_n)) <= 1), 16'd1);
    end
  end

  initial begin
    for (int j = 0; j < NC; j++) begin
      st_req[j] = 1'b0; st_addr[j] = 16'h0000; st_we[j] = 1'b0; st_dout[j] = 8'h00;
      st_bin[j] = 8'hEE; st_ext[j] = 1'b0; st_rst[j] = (j >= 2);
      ex_bus[j] = 8'h00; ex_din[j] = 8'h00; ex_lo[j] = 1'b0; ex_hi[j] = 1'b0;
      ex_wr_n[j] = 1'b1; ex_rd_n[j] = 1'b1; ex_ack[j] = 1'b0; ex_err[j] = 1'b0;
    end
    pv  = 1'b0;
    lhi = 8'h00;

    plan(5,  5,  16'h1234, 1'b1, 8'h5A, 8'h00, 0,   a1);  // miss write
    plan(12, 12, 16'h1256, 1'b0, 8'h00, 8'hC3, 0,   a2);  // page hit read
    plan(18, 18, 16'h20FF, 1'b0, 8'h00, 8'h40, 3,   a3);  // 3 wait extensions
    plan(28, 28, 16'h20AA, 1'b0, 8'h00, 8'h55, 255, a4);  // ext_wait stuck: timeout
    plan(38, 38, 16'h2011, 1'b0, 8'h00, 8'h77, 0,   a4b); // same page, must resend hi
    plan(45, 45, 16'h3300, 1'b1, 8'hA5, 8'h00, 2,   a6);  // write cut by reset
    plan_reset(50, 52);
    plan(54, 54, 16'h3301, 1'b0, 8'h00, 8'h10, 0,   a6);  // previous page after reset
    plan(61, 61, 16'h3302, 1'b1, 8'h66, 8'h00, 0,   a7);  // back-to-back chain
    plan(a7, a7 + 1, 16'h4400, 1'b0, 8'h00, 8'h90, 0, a8);
    plan(a8, a8 + 1, 16'h4401, 1'b1, 8'h3C, 8'h00, 0, a9);

    // Hand-computed pins on the model itself
    check("model_ack_miss",   0, 16'(a1),  16'd10);
    check("model_ack_hit",    0, 16'(a2),  16'd16);
    check("model_ack_ext3",   0, 16'(a3),  16'd26);
    check("model_ack_tmo",    0, 16'(a4),  16'd36);
    check("model_ack_after",  0, 16'(a4b), 16'd43);
    check("model_din_hit",    0, 16'(ex_din[16]), 16'h00C3);
    check("model_din_ext3",   0, 16'(ex_din[26]), 16'h0043);
    check("model_din_tmo",    0, 16'(ex_din[36]), 16'h00FF);
    check("model_hi_after_tmo", 0, 16'(ex_hi[41]), 16'd1);
    check("model_hi_after_rst", 0, 16'(ex_hi[57]), 16'd1);
    check("model_b2b_lo",     0, 16'(ex_lo[a7 + 2]), 16'd1);
    check("model_b2b_ack",    0, 16'(a9), 16'd74);

    for (int i = 1; i < NC; i++) begin
      @(posedge clk);
      cyc = i;
      #1;
      cpu_req  = st_req[i];
      cpu_addr = st_addr[i];
      cpu_we   = st_we[i];
      cpu_dout = st_dout[i];
      bus_in   = st_bin[i];
      ext_wait = st_ext[i];
      #2;
      if (rst_n && !st_rst[i]) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_wr_n",  i, 16'(wr_n),    16'd1);
        check("rst_async_bus",   i, 16'(bus_out), 16'd0);
        check("rst_async_ack",   i, 16'(cpu_ack), 16'd0);
        check("rst_async_ale",   i, 16'(ale_lo | ale_hi), 16'd0);
      end else begin
        rst_n = st_rst[i];
      end
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
